// File: rtl/rd_count_seq.sv
// Sequential popcount: CHUNK bits per cycle, result held until consumed.
// Optional threshold compare enabled by defining RD_COUNT_THRESH_EN.
module rd_count_seq #(
  parameter int WIDTH = 7,
  parameter int CHUNK = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_vec,
  input  logic                         abort,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic [2:0]                   rd_bits
`ifdef RD_COUNT_THRESH_EN
  ,
  input  logic [$clog2(WIDTH+1)-1:0]   thresh,
  output logic                         ge
`endif
);

  localparam int CW   = $clog2(WIDTH + 1);
  localparam int NCYC = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int NW   = $clog2(NCYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]   r_acc;
  logic [NW-1:0]   r_cnt;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_rd;
  logic [CW-1:0]   w_pop;
  logic [CW-1:0]   w_sum;
  logic [CW+2:0]   w_ext;
  logic            w_last;
  logic            w_accept;
  logic            w_step;

`ifdef RD_COUNT_THRESH_EN
  logic [CW-1:0]   r_thresh;
  logic            r_ge;
  assign ge = r_ge;
`endif

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_pop = w_pop + CW'(r_sh[i]);
    end
  end

  assign w_sum    = r_acc + w_pop;
  assign w_ext    = {3'b000, w_sum};
  assign w_last   = (r_cnt == NW'(1));
  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_step   = (r_state == S_ACC) && !abort;
  assign count    = r_count;
  assign rd_bits  = r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ACC;
      end
      S_ACC: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result registers only update on the final chunk, so they keep the
  // last result through IDLE and across aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_count  <= '0;
      r_rd     <= '0;
`ifdef RD_COUNT_THRESH_EN
      r_thresh <= '0;
      r_ge     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_sh     <= in_vec;
      r_acc    <= '0;
      r_cnt    <= NW'(NCYC);
`ifdef RD_COUNT_THRESH_EN
      r_thresh <= thresh;
`endif
    end else if (w_step) begin
      r_sh  <= r_sh >> CHUNK;
      r_acc <= w_sum;
      r_cnt <= r_cnt - NW'(1);
      if (w_last) begin
        r_count <= w_sum;
        r_rd    <= w_ext[2:0];
`ifdef RD_COUNT_THRESH_EN
        r_ge    <= (w_sum >= r_thresh);
`endif
      end
    end
  end

endmodule

// File: tb/tb_rd_count_seq.sv
// Bench for rd_count_seq: CHUNK=1 and CHUNK=3 instances, directed and
// random vectors against a popcount reference model.
module tb_rd_count_seq;

  localparam int W  = 7;
  localparam int CA = 1;
  localparam int CB = 3;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          iv  [2];
  logic          ab  [2];
  logic          orr [2];
  logic          ir  [2];
  logic          ov  [2];
  logic [W-1:0]  vec [2];
  logic [CW-1:0] cnt [2];
  logic [2:0]    rd  [2];
`ifdef RD_COUNT_THRESH_EN
  logic [CW-1:0] thr [2];
  logic          ge  [2];
`endif

  int checks = 0;
  int errors = 0;
  int last [2];

  rd_count_seq #(.WIDTH(W), .CHUNK(CA)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_vec(vec[0]),
    .abort(ab[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .count(cnt[0]), .rd_bits(rd[0])
`ifdef RD_COUNT_THRESH_EN
    , .thresh(thr[0]), .ge(ge[0])
`endif
  );

  rd_count_seq #(.WIDTH(W), .CHUNK(CB)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_vec(vec[1]),
    .abort(ab[1]), .out_valid(ov[1]), .out_ready(orr[1]),
    .count(cnt[1]), .rd_bits(rd[1])
`ifdef RD_COUNT_THRESH_EN
    , .thresh(thr[1]), .ge(ge[1])
`endif
  );

  function automatic int ncyc(int c);
    return (W + c - 1) / c;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(int s, logic [W-1:0] v, int thrv, int hold);
    int k;
    int pc;
    pc = $countones(v);
    @(negedge clk);
    chk("ready_idle", 32'(ir[s]), 1);
    iv[s]  = 1'b1;
    vec[s] = v;
    ab[s]  = 1'($urandom);
`ifdef RD_COUNT_THRESH_EN
    thr[s] = CW'(thrv);
`endif
    @(negedge clk);
    iv[s]  = 1'b0;
    ab[s]  = 1'b0;
    vec[s] = W'($urandom);
    k = 0;
    while (!ov[s] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, ncyc(s == 0 ? CA : CB));
    chk("count", 32'(cnt[s]), pc);
    chk("rd_bits", 32'(rd[s]), pc % 8);
`ifdef RD_COUNT_THRESH_EN
    chk("ge", 32'(ge[s]), (pc >= thrv) ? 1 : 0);
`endif
    for (int h = 0; h < hold; h++) begin
      iv[s]  = 1'($urandom);
      ab[s]  = 1'($urandom);
      vec[s] = W'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(ov[s]), 1);
      chk("hold_count", 32'(cnt[s]), pc);
      chk("hold_ready", 32'(ir[s]), 0);
    end
    iv[s]  = 1'b1;
    ab[s]  = 1'b0;
    orr[s] = 1'b1;
    @(negedge clk);
    iv[s]  = 1'b0;
    orr[s] = 1'b0;
    chk("release_valid", 32'(ov[s]), 0);
    chk("release_ready", 32'(ir[s]), 1);
    chk("kept_count", 32'(cnt[s]), pc);
    last[s] = pc;
  endtask

  initial begin
    int seen;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ab[s] = 1'b0; orr[s] = 1'b0;
      vec[s] = '0; last[s] = 0;
`ifdef RD_COUNT_THRESH_EN
      thr[s] = '0;
`endif
    end
    #12;
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_rd", 32'(rd[0]), 0);
    chk("rst_valid", 32'(ov[0]), 0);
    chk("rst_valid_b", 32'(ov[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ir[0]), 1);

    run(0, 7'b1010101, 0, 0);
    run(1, 7'b1111111, 7, 2);
    run(1, 7'b0000000, 1, 1);
    run(0, 7'b1100110, 2, 5);

    // abort on the third ACC cycle
    @(negedge clk);
    iv[0] = 1'b1; vec[0] = 7'b1111111;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    chk("abort_valid", 32'(ov[0]), 0);
    chk("abort_ready", 32'(ir[0]), 1);
    chk("abort_count", 32'(cnt[0]), last[0]);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run(0, 7'b0000011, 2, 1);

    // reset in the middle of ACC
    @(negedge clk);
    iv[0] = 1'b1; vec[0] = 7'b1111111;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(cnt[0]), 0);
    chk("midrst_rd", 32'(rd[0]), 0);
    chk("midrst_valid", 32'(ov[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last[0] = 0; last[1] = 0;
    seen = 0;
    repeat (ncyc(CA) + 3) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    chk("midrst_ready", 32'(ir[0]), 1);
    chk("midrst_count_b", 32'(cnt[1]), last[1]);

    run(0, 7'b0111000, 3, 0);
    run(0, 7'b0111000, 4, 0);

    for (int i = 0; i < 24; i++) begin
      run(i % 2, W'($urandom), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_count_seq.md
RD_COUNT_SEQ -- requirements
Module: rd_count_seq

Interface
REQ-001 Parameter WIDTH, default 7, number of input bits whose weight is counted (WIDTH >= 2).
REQ-002 Parameter CHUNK, default 1, input bits consumed per cycle (1 <= CHUNK <= WIDTH).
REQ-003 Derived CW = clog2(WIDTH+1) and NCYC = ceil(WIDTH/CHUNK); both are localparams, not overridable.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 in_valid  input  1  in_vec is valid this cycle.
REQ-007 in_ready  output  1  block can accept a vector this cycle.
REQ-008 in_vec  input  WIDTH  operand vector.
REQ-009 abort  input  1  synchronous cancel of a computation in progress.
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 count  output  CW  number of ones in the accepted in_vec.
REQ-013 rd_bits  output  3  count[2:0], zero-extended when CW < 3 (rd-style symmetric function outputs f0..f2).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACC, HOLD.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 captures in_vec into a shift register, clears the accumulator, loads chunk counter with NCYC, and moves to ACC.
REQ-016 ACC: in_ready=0; each cycle adds the popcount of the low CHUNK bits of the shift register to the accumulator, shifts right by CHUNK, decrements the chunk counter.
REQ-017 Bit positions at or above WIDTH in the final chunk SHALL be treated as zero (zero-padding on shift).
REQ-018 After the NCYC-th ACC cycle the FSM SHALL enter HOLD; out_valid rises exactly NCYC cycles after the accepting edge.
REQ-019 HOLD: out_valid=1, in_ready=0; count, rd_bits held stable while out_ready=0.
REQ-020 HOLD with out_ready=1 SHALL return to IDLE at that edge; a new vector cannot be accepted in that same cycle.
REQ-021 abort=1 in ACC SHALL return to IDLE next edge with no out_valid pulse; abort in IDLE or HOLD SHALL be ignored.
REQ-022 in_valid while in_ready=0 SHALL be ignored; no input buffering.
REQ-023 Accumulator width is CW; no overflow is possible since count <= WIDTH.
REQ-024 count and rd_bits SHALL be registered outputs; outside HOLD their values are don't-care to consumers but SHALL equal the last result or zero after reset.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, count=0, rd_bits=0, accumulator and shift register cleared.
REQ-026 Reset asserted mid-ACC or mid-HOLD SHALL discard the computation; no out_valid follows release.

Configuration
REQ-027 Macro RD_COUNT_THRESH_EN, when defined, SHALL add input thresh (CW bits, sampled with in_vec on accept) and registered output ge (1 bit) = (count >= thresh), valid with out_valid, reset 0.
REQ-028 Without RD_COUNT_THRESH_EN the thresh and ge ports and their logic SHALL not exist; all other behaviour identical.

Verification
REQ-029 WIDTH=7, CHUNK=1, in_vec=7'b1010101 accepted -> out_valid after 7 cycles, count=4, rd_bits=3'b100.
REQ-030 WIDTH=7, CHUNK=3, in_vec=7'b1111111 -> out_valid after 3 cycles, count=7, rd_bits=3'b111; in_vec=0 -> count=0.
REQ-031 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid and count stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-032 abort asserted on ACC cycle 3 (CHUNK=1) -> IDLE next edge, no out_valid; next vector 7'b0000011 gives count=2.
REQ-033 rst_n low mid-ACC -> outputs zero immediately, no out_valid after release; with RD_COUNT_THRESH_EN, in_vec=7'b0111000, thresh=3 -> ge=1; thresh=4 -> ge=0.
